// File: rtl/button_pkg.sv
// Shared mode encodings, per-channel FSM states and output payload for button_ctrl.
package button_pkg;

  localparam logic [1:0] MODE_TOGGLE = 2'b00;
  localparam logic [1:0] MODE_MOMENT = 2'b01;
  localparam logic [1:0] MODE_LONG   = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } chan_state_e;

  typedef enum logic [1:0] {
    RULE_TOGGLE = 2'd0,
    RULE_MOMENT = 2'd1,
    RULE_LONG   = 2'd2
  } led_rule_e;

  // Registered per-channel outputs, kept together so they share one register.
  typedef struct packed {
    logic led;
    logic press;
    logic long_p;
  } chan_out_t;

  // 2'b11 is an alias of toggle.
  function automatic led_rule_e decode_mode(input logic [1:0] mode);
    led_rule_e rule;
    rule = RULE_TOGGLE;
    if (mode == MODE_MOMENT) begin
      rule = RULE_MOMENT;
    end else if (mode == MODE_LONG) begin
      rule = RULE_LONG;
    end else if (mode == MODE_TOGGLE) begin
      rule = RULE_TOGGLE;
    end
    return rule;
  endfunction

endpackage

// File: rtl/button_chan.sv
// One button channel: 2-FF synchroniser, debouncer, press/long-press FSM and LED register.
module button_chan
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned LONG_CYC     = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       button,
  input  logic [1:0] mode,
  output logic       led,
  output logic       press_pulse,
  output logic       long_pulse
);

  localparam int unsigned CNT_W = $clog2(LONG_CYC + 1);
  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_CYC - 1);

  logic             sync1;
  logic             s;
  logic             db;
  logic             db_nxt;
  logic [CNT_W-1:0] dcnt;
  logic [CNT_W-1:0] dcnt_nxt;
  logic [CNT_W-1:0] hcnt;
  logic [CNT_W-1:0] hcnt_nxt;
  chan_state_e      state;
  chan_state_e      state_nxt;
  chan_out_t        out_q;
  chan_out_t        out_nxt;

  // Two-flop synchroniser; the raw pin feeds nothing else.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= button;
      s     <= sync1;
    end
  end

  // Debounce: accept a new level after DEBOUNCE_CYC consecutive disagreeing samples.
  always_comb begin
    db_nxt   = db;
    dcnt_nxt = '0;
    if (s != db) begin
      if (dcnt == DB_LAST) begin
        db_nxt   = s;
        dcnt_nxt = '0;
      end else begin
        dcnt_nxt = dcnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db   <= 1'b0;
      dcnt <= '0;
    end else begin
      db   <= db_nxt;
      dcnt <= dcnt_nxt;
    end
  end

  // FSM follows db_nxt so the press pulse and LED toggle land on the same edge as the db rise.
  always_comb begin
    state_nxt      = state;
    hcnt_nxt       = hcnt;
    out_nxt.press  = 1'b0;
    out_nxt.long_p = 1'b0;
    out_nxt.led    = out_q.led;

    case (state)
      IDLE: begin
        if (db_nxt) begin
          state_nxt     = PRESSED;
          hcnt_nxt      = '0;
          out_nxt.press = 1'b1;
        end
      end
      PRESSED: begin
        if (!db_nxt) begin
          state_nxt = IDLE;
        end else if (hcnt == HOLD_LAST) begin
          state_nxt      = LONG;
          out_nxt.long_p = 1'b1;
        end else begin
          hcnt_nxt = hcnt + CNT_W'(1);
        end
      end
      LONG: begin
        if (!db_nxt) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    case (decode_mode(mode))
      RULE_TOGGLE: if (out_nxt.press)  out_nxt.led = ~out_q.led;
      RULE_MOMENT: out_nxt.led = db;
      RULE_LONG:   if (out_nxt.long_p) out_nxt.led = ~out_q.led;
      default:     out_nxt.led = out_q.led;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      hcnt  <= '0;
      out_q <= '0;
    end else begin
      state <= state_nxt;
      hcnt  <= hcnt_nxt;
      out_q <= out_nxt;
    end
  end

  assign led         = out_q.led;
  assign press_pulse = out_q.press;
  assign long_pulse  = out_q.long_p;

endmodule

// File: rtl/button_ctrl.sv
// Multi-channel button front end: N_CH independent button_chan instances sharing one mode input.
module button_ctrl
  import button_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned DEBOUNCE_CYC = 4,
  parameter int unsigned LONG_CYC     = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] button,
  input  logic [1:0]      mode,
  output logic [N_CH-1:0] led,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] long_pulse
);

  for (genvar ch = 0; ch < int'(N_CH); ch++) begin : g_chan
    button_chan #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .LONG_CYC     (LONG_CYC)
    ) u_chan (
      .clk         (clk),
      .reset       (reset),
      .button      (button[ch]),
      .mode        (mode),
      .led         (led[ch]),
      .press_pulse (press_pulse[ch]),
      .long_pulse  (long_pulse[ch])
    );
  end

endmodule

// File: tb/tb_button_ctrl.sv
// Directed bench for button_ctrl: debounce latency, glitch rejection, LED modes and reset behaviour.
module tb_button_ctrl;

  localparam int N_CH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [N_CH-1:0] button = '0;
  logic [1:0]      mode = 2'b00;
  logic [N_CH-1:0] led;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] long_pulse;

  int n_vec = 0;
  int n_err = 0;
  int cyc;
  int pcnt[N_CH];
  int pfirst[N_CH];
  int lcnt[N_CH];
  int lfirst[N_CH];

  always #5 clk = ~clk;

  button_ctrl #(
    .N_CH         (N_CH),
    .DEBOUNCE_CYC (4),
    .LONG_CYC     (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .button      (button),
    .mode        (mode),
    .led         (led),
    .press_pulse (press_pulse),
    .long_pulse  (long_pulse)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Cycle index 0 is the first clock edge after mark().
  task automatic mark();
    cyc = -1;
    for (int c = 0; c < N_CH; c++) begin
      pcnt[c] = 0; pfirst[c] = -1; lcnt[c] = 0; lfirst[c] = -1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      for (int c = 0; c < N_CH; c++) begin
        if (press_pulse[c]) begin
          pcnt[c]++;
          if (pfirst[c] < 0) pfirst[c] = cyc;
        end
        if (long_pulse[c]) begin
          lcnt[c]++;
          if (lfirst[c] < 0) lfirst[c] = cyc;
        end
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst led", 32'(led), 32'h0);
    chk("rst press", 32'(press_pulse), 32'h0);
    chk("rst long", 32'(long_pulse), 32'h0);
    reset = 1'b1;

    // Toggle mode, two long holds on channel 0
    for (int p = 0; p < 2; p++) begin
      mark();
      button[0] = 1'b1;
      run(30);
      button[0] = 1'b0;
      run(30);
      chk($sformatf("t2 pcnt p%0d", p), 32'(pcnt[0]), 32'd1);
      chk($sformatf("t2 pfirst p%0d", p), 32'(pfirst[0]), 32'd5);
      chk($sformatf("t2 lcnt p%0d", p), 32'(lcnt[0]), 32'd1);
      chk($sformatf("t2 lfirst p%0d", p), 32'(lfirst[0]), 32'd21);
      chk($sformatf("t2 led p%0d", p), 32'(led), (p == 0) ? 32'h1 : 32'h0);
    end

    // Glitch of DEBOUNCE_CYC-1 cycles is rejected
    mark();
    button[1] = 1'b1;
    run(3);
    button[1] = 1'b0;
    run(10);
    chk("t3 glitch pcnt", 32'(pcnt[1]), 32'd0);
    chk("t3 glitch led", 32'(led), 32'h0);

    // Bounce then steady press gives one pulse
    mark();
    for (int i = 0; i < 10; i++) begin
      button[1] = (i % 2 == 0);
      run(1);
    end
    button[1] = 1'b1;
    run(30);
    button[1] = 1'b0;
    run(10);
    chk("t3 bounce pcnt", 32'(pcnt[1]), 32'd1);
    chk("t3 bounce pfirst", 32'(pfirst[1]), 32'd15);
    chk("t3 bounce lcnt", 32'(lcnt[1]), 32'd1);
    chk("t3 bounce lfirst", 32'(lfirst[1]), 32'd31);
    chk("t3 bounce led", 32'(led), 32'h2);

    // Long-toggle mode: short hold leaves LED, long hold toggles
    mode = 2'b10;
    mark();
    button[2] = 1'b1;
    run(10);
    button[2] = 1'b0;
    run(10);
    chk("t4 short pcnt", 32'(pcnt[2]), 32'd1);
    chk("t4 short lcnt", 32'(lcnt[2]), 32'd0);
    chk("t4 short led", 32'(led), 32'h2);
    mark();
    button[2] = 1'b1;
    run(40);
    button[2] = 1'b0;
    run(10);
    chk("t4 long lcnt", 32'(lcnt[2]), 32'd1);
    chk("t4 long lfirst", 32'(lfirst[2]), 32'd21);
    chk("t4 long led", 32'(led), 32'h6);

    // Momentary mode: led follows db one cycle late; switching away keeps the level
    mode = 2'b01;
    mark();
    button[3] = 1'b1;
    run(5);
    chk("t5 led c4", 32'(led), 32'h0);
    run(1);
    chk("t5 press c5", 32'(press_pulse), 32'h8);
    chk("t5 led c5", 32'(led), 32'h0);
    run(1);
    chk("t5 led c6", 32'(led), 32'h8);
    run(1);
    mode = 2'b00;
    run(3);
    chk("t5 led after switch", 32'(led), 32'h8);
    button[3] = 1'b0;
    run(10);
    chk("t5 led after release", 32'(led), 32'h8);

    // Simultaneous press, async reset mid-hold, re-qualification
    mark();
    button = 4'hF;
    run(8);
    for (int c = 0; c < N_CH; c++) begin
      chk($sformatf("t6 pfirst%0d", c), 32'(pfirst[c]), 32'd5);
    end
    chk("t6 led before rst", 32'(led), 32'h7);
    #3;
    reset = 1'b0;
    #1;
    chk("t6 async led", 32'(led), 32'h0);
    chk("t6 async press", 32'(press_pulse), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    mark();
    run(10);
    for (int c = 0; c < N_CH; c++) begin
      chk($sformatf("t6 re pcnt%0d", c), 32'(pcnt[c]), 32'd1);
      chk($sformatf("t6 re pfirst%0d", c), 32'(pfirst[c]), 32'd5);
    end
    chk("t6 re led", 32'(led), 32'hF);
    run(12);
    for (int c = 0; c < N_CH; c++) begin
      chk($sformatf("t6 lfirst%0d", c), 32'(lfirst[c]), 32'd21);
    end
    chk("t6 led final", 32'(led), 32'hF);
    button = '0;
    run(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
